weight_stream_mem: RTL and testbench

Multi-channel weight store for one ELM hidden layer: `numChannels` neuron banks, each `2**addressWidth` × `dataWidth`, loaded word-by-word through a write port and read back as a burst stream with valid/ready backpressure. It sits between the AXI weight-load path and the neuron MAC array. One `start` streams `len` consecutive addresses from `baseAddr`, all channels in lockstep, so every neuron gets its weight for the same input index on the same beat.

---
 rtl/weight_stream_mem.sv | 177 +++++++++++++++++
 tb/tb_weight_stream_mem.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_mem.sv
// weight_stream_mem
//
// Multi-channel weight store for one ELM hidden layer. Each of the
// numChannels neuron banks holds 2**addressWidth words of dataWidth bits.
// Banks are loaded one word at a time through the write port. A burst
// started with `start` reads `len` consecutive addresses from `baseAddr`
// out of every bank in lockstep, so all neurons see the weight for the
// same input index on the same beat.
//
// Ports
//   clk, rst             : single rising-edge clock, synchronous active-high reset
//   wen/wchan/waddr/win  : word write into bank `wchan` (accepted in any state)
//   start/baseAddr/len   : burst request, only looked at while idle
//   busy                 : burst in progress, including the done cycle
//   wout/wvalid/wready   : beat stream, channel k at wout[k*dataWidth +: dataWidth]
//   wlast                : current beat is the final beat of the burst
//   done                 : one-cycle pulse after the last handshake
module weight_stream_mem #(
    parameter int numChannels  = 4,
    parameter int chanWidth    = 2,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [chanWidth-1:0]             wchan,
    input  logic [addressWidth-1:0]          waddr,
    input  logic [dataWidth-1:0]             win,
    input  logic                             start,
    input  logic [addressWidth-1:0]          baseAddr,
    input  logic [addressWidth:0]            len,
    output logic                             busy,
    output logic [numChannels*dataWidth-1:0] wout,
    output logic                             wvalid,
    input  logic                             wready,
    output logic                             wlast,
    output logic                             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam logic [addressWidth-1:0] ADDR_STEP = 1;
    localparam logic [addressWidth:0]   REM_ONE   = 1;

    state_t                  state_q, state_d;
    logic [addressWidth-1:0] addr_q, addr_d;
    logic [addressWidth:0]   remaining_q, remaining_d;
    logic [1:0]              count_q, count_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              last_q, last_d;
    logic                    issue;
    logic                    pop;

    // The bank read lands directly in the FIFO slot at the issuing edge, so
    // a read is never in flight across a cycle boundary. That leaves the
    // credit check as "room in the FIFO after this cycle's pop".
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_d      = last_q;

        pop   = (count_q != 2'd0) && wready;
        issue = (state_q == RUN) && (remaining_q != '0) && ((count_q != 2'd2) || pop);

        if (issue) begin
            last_d[wr_ptr_q] = (remaining_q == REM_ONE);
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({issue, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d      = baseAddr;
                        remaining_d = len;
                        state_d     = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                // Address wraps naturally at the top of the bank.
                if (issue) begin
                    addr_d      = addr_q + ADDR_STEP;
                    remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as soon as the final beat is handed over this cycle.
                if (count_d == 2'd0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            last_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_q      <= last_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN);
    assign wvalid = (count_q != 2'd0);
    assign wlast  = wvalid && last_q[rd_ptr_q];

    // One bank plus its two FIFO data slots per channel. A write whose
    // channel number has no bank matches nothing and is dropped. The bank
    // read uses the pre-write contents, giving read-first behaviour when a
    // write hits the address being streamed. Bank and slots are never reset
    // so weights survive a reset; wout is gated to zero while the FIFO is empty.
    for (genvar k = 0; k < numChannels; k++) begin : g_bank
        localparam int unsigned CHAN_IDX = k;

        logic [dataWidth-1:0] bank [2**addressWidth];
        logic [dataWidth-1:0] slot [2];
        logic                 bank_wen;

        assign bank_wen = wen && (wchan == CHAN_IDX[chanWidth-1:0]);

        always_ff @(posedge clk) begin
            if (bank_wen) begin
                bank[waddr] <= win;
            end
            if (issue) begin
                slot[wr_ptr_q] <= bank[addr_q];
            end
        end

        assign wout[k*dataWidth +: dataWidth] = wvalid ? slot[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_weight_stream_mem.sv
// tb_weight_stream_mem
//
// Directed self-checking bench for weight_stream_mem. A shadow copy of the
// bank contents, updated whenever the bench writes, supplies the expected
// beat data; cycle positions of busy/done/beats are hand-derived from the
// start cycle.
module tb_weight_stream_mem;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int AW     = 10;
    localparam int DW     = 16;
    localparam int OW     = NUM_CH * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            wen;
    logic [CH_W-1:0] wchan;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   win;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     len;
    logic            busy;
    logic [OW-1:0]   wout;
    logic            wvalid;
    logic            wready;
    logic            wlast;
    logic            done;

    logic [DW-1:0]   model [NUM_CH][2**AW];
    logic [OW-1:0]   exp_arr [8];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    weight_stream_mem #(
        .numChannels (NUM_CH),
        .chanWidth   (CH_W),
        .addressWidth(AW),
        .dataWidth   (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .wchan   (wchan),
        .waddr   (waddr),
        .win     (win),
        .start   (start),
        .baseAddr(base_addr),
        .len     (len),
        .busy    (busy),
        .wout    (wout),
        .wvalid  (wvalid),
        .wready  (wready),
        .wlast   (wlast),
        .done    (done)
    );

    // Advance to just after the next rising edge; outputs are sampled and
    // inputs driven at this point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [OW-1:0] observed,
                               input logic [OW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [OW-1:0] exp_beat(input logic [AW-1:0] a);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            r[k*DW +: DW] = model[k][a];
        end
        return r;
    endfunction

    task automatic write_word(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen   = 1'b1;
        wchan = ch[CH_W-1:0];
        waddr = a;
        win   = d;
        tick();
        wen = 1'b0;
        model[ch][a] = d;
    endtask

    // Present a start request for one cycle; returns at cycle T+1.
    task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] n);
        start     = 1'b1;
        base_addr = b;
        len       = n;
        tick();
        start = 1'b0;
    endtask

    // Run a burst under a repeating 4-cycle wready pattern, checking every
    // handshake against the model and output stability while stalled.
    task automatic run_burst(input string tag, input logic [AW-1:0] b, input int n,
                             input logic [3:0] pattern);
        int            idx;
        bit            saw_done;
        bit            prev_stall;
        logic [OW-1:0] prev_wout;
        logic [AW-1:0] a;
        idx        = 0;
        saw_done   = 1'b0;
        prev_stall = 1'b0;
        prev_wout  = '0;
        applyStimulus(b, n[AW:0]);
        for (int cyc = 0; cyc < 200; cyc++) begin
            wready = pattern[cyc % 4];
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            if (prev_stall) begin
                checkOutput({tag, " hold valid"}, OW'(wvalid), OW'(1));
                checkOutput({tag, " hold data"}, wout, prev_wout);
            end
            if (wvalid && wready) begin
                a = b + idx[AW-1:0];
                checkOutput({tag, " data"}, wout, exp_beat(a));
                checkOutput({tag, " last"}, OW'(wlast), OW'(idx == n - 1));
                idx++;
            end
            prev_stall = wvalid && !wready;
            prev_wout  = wout;
            tick();
        end
        checkOutput({tag, " done seen"}, OW'(saw_done), OW'(1));
        checkOutput({tag, " beat count"}, OW'(idx), OW'(n));
        tick();
        checkOutput({tag, " idle after done"}, OW'(busy), OW'(0));
        wready = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] a;

        rst       = 1'b1;
        wen       = 1'b0;
        wchan     = '0;
        waddr     = '0;
        win       = '0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        wready    = 1'b1;
        repeat (3) tick();
        checkOutput("reset busy", OW'(busy), OW'(0));
        checkOutput("reset wvalid", OW'(wvalid), OW'(0));
        checkOutput("reset wlast", OW'(wlast), OW'(0));
        checkOutput("reset done", OW'(done), OW'(0));
        checkOutput("reset wout", wout, '0);
        rst = 1'b0;
        tick();

        // Load bank k, address a with (k<<12)|a for the low addresses and the top two.
        for (int i = 0; i < 48; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                write_word(k, AW'(i), DW'((k << 12) | i));
            end
        end
        for (int i = 1022; i < 1024; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                write_word(k, AW'(i), DW'((k << 12) | i));
            end
        end

        // Full-rate burst of 16 from address 0 with exact timing.
        wready = 1'b1;
        applyStimulus(AW'(0), 11'd16);
        checkOutput("t1 busy at T+1", OW'(busy), OW'(1));
        checkOutput("t1 wvalid at T+1", OW'(wvalid), OW'(0));
        for (int i = 0; i < 16; i++) begin
            tick();
            checkOutput("t1 wvalid", OW'(wvalid), OW'(1));
            checkOutput("t1 data", wout, exp_beat(AW'(i)));
            checkOutput("t1 wlast", OW'(wlast), OW'(i == 15));
            checkOutput("t1 done early", OW'(done), OW'(0));
        end
        tick();
        checkOutput("t1 done at T+18", OW'(done), OW'(1));
        checkOutput("t1 busy at T+18", OW'(busy), OW'(1));
        checkOutput("t1 wvalid at T+18", OW'(wvalid), OW'(0));
        tick();
        checkOutput("t1 busy at T+19", OW'(busy), OW'(0));
        checkOutput("t1 done at T+19", OW'(done), OW'(0));

        // Address wrap: 1022, 1023, 0, 1.
        applyStimulus(AW'(1022), 11'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            a = AW'(1022 + i);
            checkOutput("wrap data", wout, exp_beat(a));
            checkOutput("wrap wlast", OW'(wlast), OW'(i == 3));
        end
        tick();
        checkOutput("wrap done", OW'(done), OW'(1));
        tick();

        // Backpressure with wready 1,0,0,1 repeating.
        run_burst("toggle", AW'(8), 8, 4'b1001);

        // Mid-burst writes: 0x25 ahead of its read, 0x22 in its read cycle.
        applyStimulus(AW'(32), 11'd8);
        wen   = 1'b1;
        wchan = 2'd1;
        waddr = AW'(37);
        win   = 16'hAAAA;
        model[1][37] = 16'hAAAA;
        for (int i = 0; i < 8; i++) begin
            exp_arr[i] = exp_beat(AW'(32 + i));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            wen = 1'b0;
            if (i == 1) begin
                wen   = 1'b1;
                wchan = 2'd2;
                waddr = AW'(34);
                win   = 16'hBBBB;
            end
            checkOutput("midwr wvalid", OW'(wvalid), OW'(1));
            checkOutput("midwr data", wout, exp_arr[i]);
        end
        model[2][34] = 16'hBBBB;
        tick();
        wen = 1'b0;
        checkOutput("midwr done", OW'(done), OW'(1));
        tick();
        run_burst("midwr readback", AW'(34), 4, 4'b1111);

        // start while busy is ignored.
        applyStimulus(AW'(0), 11'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            start     = (i == 0);
            base_addr = AW'(16);
            len       = 11'd2;
            checkOutput("busy-start data", wout, exp_beat(AW'(i)));
            checkOutput("busy-start wlast", OW'(wlast), OW'(i == 3));
        end
        start = 1'b0;
        tick();
        checkOutput("busy-start done", OW'(done), OW'(1));
        tick();
        checkOutput("busy-start idle", OW'(busy), OW'(0));
        checkOutput("busy-start no extra beat", OW'(wvalid), OW'(0));

        // Zero-length burst.
        applyStimulus(AW'(5), 11'd0);
        checkOutput("len0 busy", OW'(busy), OW'(1));
        checkOutput("len0 done", OW'(done), OW'(1));
        checkOutput("len0 wvalid", OW'(wvalid), OW'(0));
        tick();
        checkOutput("len0 busy after", OW'(busy), OW'(0));
        checkOutput("len0 done after", OW'(done), OW'(0));
        checkOutput("len0 wvalid after", OW'(wvalid), OW'(0));

        // Reset at beat 3 of a 10-beat burst, then a fresh burst straight away.
        applyStimulus(AW'(0), 11'd10);
        repeat (4) tick();
        checkOutput("rst beat3 data", wout, exp_beat(AW'(3)));
        rst = 1'b1;
        tick();
        checkOutput("rst busy", OW'(busy), OW'(0));
        checkOutput("rst wvalid", OW'(wvalid), OW'(0));
        checkOutput("rst wlast", OW'(wlast), OW'(0));
        checkOutput("rst done", OW'(done), OW'(0));
        checkOutput("rst wout", wout, '0);
        rst = 1'b0;
        run_burst("post-reset", AW'(16), 3, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
